tt_sel_seq: RTL and testbench

Clocked design-selection and power sequencer. It succeeds the pad-driven select/enable path, where ctrl_sel_rst_n, ctrl_sel_inc and ctrl_ena feed the controller directly. It synchronises the three control pads, keeps a parametrised selection address counter, and sequences user-module power-gate and enable with programmable power-up and power-down delays. It sits between the control-high pads and the controller/mux address spine. It drives sel_addr, um_pg_vdd and um_ena for the selected design.

---
 rtl/tt_sel_seq.sv | 165 ++++++++++++++++
 tb/tb_tt_sel_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/tt_sel_seq.sv
// Design-selection and power sequencer: synchronises the control pads,
// steps the selection address and sequences power-gate and enable.
module tt_sel_seq #(
  parameter int N_SEL = 512,
  parameter int SYNC_STAGES = 2,
  parameter int PU_DLY = 16,
  parameter int PD_DLY = 4,
  localparam int AW = $clog2(N_SEL)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pad_sel_rst_n,
  input  logic          pad_sel_inc,
  input  logic          pad_ena,
  output logic [AW-1:0] sel_addr,
  output logic          um_pg_vdd,
  output logic          um_ena,
  output logic          busy,
  output logic          err_inc_busy
);

  localparam int MAXD = (PU_DLY > PD_DLY) ? PU_DLY : PD_DLY;
  localparam int CW = (MAXD > 1) ? $clog2(MAXD) : 1;
  localparam logic [CW-1:0] PU_LD = CW'(PU_DLY - 1);
  localparam logic [CW-1:0] PD_LD = CW'(PD_DLY - 1);
  localparam logic [AW-1:0] ADDR_MAX = AW'(N_SEL - 1);

  typedef enum logic [1:0] {
    IDLE,
    PWR_UP,
    ACTIVE,
    PWR_DN
  } state_e;

  logic [SYNC_STAGES-1:0] ena_sync_q, ena_sync_d;
  logic [SYNC_STAGES-1:0] srn_sync_q, srn_sync_d;
  logic [SYNC_STAGES-1:0] inc_sync_q, inc_sync_d;
  logic ena_s_q, ena_s_d;
  logic srn_s_q, srn_s_d;
  logic inc_last_q, inc_last_d;
  logic inc_p_q, inc_p_d;

  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic pg_q, pg_d;
  logic en_q, en_d;
  logic busy_q, busy_d;
  logic err_q, err_d;

  logic sel_rst;
  logic abort;

  always_comb begin
    ena_sync_d = {ena_sync_q[SYNC_STAGES-2:0], pad_ena};
    srn_sync_d = {srn_sync_q[SYNC_STAGES-2:0], pad_sel_rst_n};
    inc_sync_d = {inc_sync_q[SYNC_STAGES-2:0], pad_sel_inc};
    ena_s_d = ena_sync_q[SYNC_STAGES-1];
    srn_s_d = srn_sync_q[SYNC_STAGES-1];
    inc_last_d = inc_sync_q[SYNC_STAGES-1];
    inc_p_d = inc_sync_q[SYNC_STAGES-1] & ~inc_last_q;
  end

  assign sel_rst = ~srn_s_q;
  assign abort = ~ena_s_q | sel_rst;

  // Increments are only honoured in IDLE so the address is stable while powered.
  always_comb begin
    addr_d = addr_q;
    err_d = err_q;
    if (sel_rst) begin
      addr_d = '0;
    end else if (inc_p_q) begin
      if (state_q == IDLE) begin
        addr_d = (addr_q == ADDR_MAX) ? '0 : addr_q + 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (ena_s_q && !sel_rst) begin
          state_d = PWR_UP;
          cnt_d = PU_LD;
        end
      end
      PWR_UP: begin
        if (abort) begin
          state_d = PWR_DN;
          cnt_d = PD_LD;
        end else if (cnt_q == '0) begin
          state_d = ACTIVE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ACTIVE: begin
        if (abort) begin
          state_d = PWR_DN;
          cnt_d = PD_LD;
        end
      end
      PWR_DN: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d = '0;
      end
    endcase
    pg_d = (state_d != IDLE);
    en_d = (state_d == ACTIVE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ena_sync_q <= '0;
      srn_sync_q <= '0;
      inc_sync_q <= '0;
      ena_s_q <= 1'b0;
      srn_s_q <= 1'b0;
      inc_last_q <= 1'b0;
      inc_p_q <= 1'b0;
      state_q <= IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      pg_q <= 1'b0;
      en_q <= 1'b0;
      busy_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ena_sync_q <= ena_sync_d;
      srn_sync_q <= srn_sync_d;
      inc_sync_q <= inc_sync_d;
      ena_s_q <= ena_s_d;
      srn_s_q <= srn_s_d;
      inc_last_q <= inc_last_d;
      inc_p_q <= inc_p_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      pg_q <= pg_d;
      en_q <= en_d;
      busy_q <= busy_d;
      err_q <= err_d;
    end
  end

  assign sel_addr = addr_q;
  assign um_pg_vdd = pg_q;
  assign um_ena = en_q;
  assign busy = busy_q;
  assign err_inc_busy = err_q;

endmodule

// File: tb/tb_tt_sel_seq.sv
// Scoreboard bench for tt_sel_seq: pad-level reference model feeds a
// queue of expected outputs, a monitor pops and compares every cycle.
module tb_tt_sel_seq;

  localparam int N_SEL = 6;
  localparam int S = 2;
  localparam int PU = 16;
  localparam int PD = 4;
  localparam int AW = $clog2(N_SEL);

  logic clk = 1'b1;
  logic rst = 1'b1;
  logic pad_sel_rst_n = 1'b1;
  logic pad_sel_inc = 1'b0;
  logic pad_ena = 1'b0;
  logic [AW-1:0] sel_addr;
  logic um_pg_vdd;
  logic um_ena;
  logic busy;
  logic err_inc_busy;

  always #5 clk = ~clk;

  tt_sel_seq #(
    .N_SEL(N_SEL),
    .SYNC_STAGES(S),
    .PU_DLY(PU),
    .PD_DLY(PD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pad_sel_rst_n(pad_sel_rst_n),
    .pad_sel_inc(pad_sel_inc),
    .pad_ena(pad_ena),
    .sel_addr(sel_addr),
    .um_pg_vdd(um_pg_vdd),
    .um_ena(um_ena),
    .busy(busy),
    .err_inc_busy(err_inc_busy)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic pg;
    logic en;
    logic busy;
    logic err;
  } exp_t;

  exp_t sb_q[$];
  int total = 0;
  int bad = 0;

  // phase: 0 off, 1 powering up, 2 enabled, 3 powering down
  int m_phase = 0;
  int m_entry = 0;
  int m_edge = 0;
  int m_addr = 0;
  bit m_err = 0;
  bit h_ena[S+3];
  bit h_srn[S+3];
  bit h_inc[S+3];

  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", n, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit e,
                            input bit sn, input bit inc);
    bit ena_l, srst, incp;
    m_edge++;
    if (r) begin
      m_phase = 0;
      m_addr = 0;
      m_err = 0;
      for (int i = 0; i < S + 3; i++) begin
        h_ena[i] = 0;
        h_srn[i] = 0;
        h_inc[i] = 0;
      end
    end else begin
      for (int i = S + 2; i > 0; i--) begin
        h_ena[i] = h_ena[i-1];
        h_srn[i] = h_srn[i-1];
        h_inc[i] = h_inc[i-1];
      end
      h_ena[0] = e;
      h_srn[0] = sn;
      h_inc[0] = inc;
      // pad values reach the sequencer S+1 edges after being sampled
      ena_l = h_ena[S+1];
      srst = !h_srn[S+1];
      incp = h_inc[S+1] && !h_inc[S+2];
      if (srst) m_addr = 0;
      else if (incp) begin
        if (m_phase == 0) m_addr = (m_addr + 1) % N_SEL;
        else m_err = 1;
      end
      case (m_phase)
        0: if (ena_l && !srst) begin
          m_phase = 1;
          m_entry = m_edge;
        end
        1: if (!ena_l || srst) begin
          m_phase = 3;
          m_entry = m_edge;
        end else if (m_edge - m_entry >= PU) m_phase = 2;
        2: if (!ena_l || srst) begin
          m_phase = 3;
          m_entry = m_edge;
        end
        default: if (m_edge - m_entry >= PD) m_phase = 0;
      endcase
    end
  endtask

  task automatic drive(input bit r, input bit e,
                       input bit sn, input bit inc);
    exp_t x;
    @(negedge clk);
    rst = r;
    pad_ena = e;
    pad_sel_rst_n = sn;
    pad_sel_inc = inc;
    model_edge(r, e, sn, inc);
    x.addr = AW'(m_addr);
    x.pg = (m_phase != 0);
    x.en = (m_phase == 2);
    x.busy = (m_phase != 0);
    x.err = m_err;
    sb_q.push_back(x);
  endtask

  task automatic inc_pulse(input bit e);
    repeat (4) drive(0, e, 1, 1);
    repeat (4) drive(0, e, 1, 0);
  endtask

  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        x = sb_q.pop_front();
        chk("sel_addr", sel_addr, x.addr);
        chk("um_pg_vdd", um_pg_vdd, x.pg);
        chk("um_ena", um_ena, x.en);
        chk("busy", busy, x.busy);
        chk("err_inc_busy", err_inc_busy, x.err);
        chk("ena_implies_pg", um_ena & ~um_pg_vdd, 0);
      end
    end
  end

  initial begin
    bit e, sn, inc;
    int len;
    repeat (2) drive(1, 0, 1, 0);
    repeat (6) drive(0, 0, 1, 0);
    repeat (3) inc_pulse(0);
    repeat (5) inc_pulse(0);
    repeat (4) drive(0, 0, 0, 1);
    repeat (4) drive(0, 0, 1, 0);
    repeat (30) drive(0, 1, 1, 0);
    repeat (12) drive(0, 0, 1, 0);
    repeat (11) drive(0, 1, 1, 0);
    repeat (12) drive(0, 0, 1, 0);
    repeat (2) inc_pulse(0);
    repeat (25) drive(0, 1, 1, 0);
    inc_pulse(1);
    repeat (3) drive(0, 1, 0, 0);
    repeat (40) drive(0, 1, 1, 0);
    drive(1, 1, 1, 0);
    repeat (10) drive(0, 0, 1, 0);
    inc = 0;
    for (int seg = 0; seg < 400; seg++) begin
      e = ($urandom_range(0, 3) != 0);
      sn = ($urandom_range(0, 7) != 0);
      len = $urandom_range(1, 40);
      if ($urandom_range(0, 39) == 0) drive(1, e, sn, inc);
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 2) == 0) inc = !inc;
        drive(0, e, sn, inc);
      end
    end
    repeat (3) drive(0, 0, 1, 0);
    @(negedge clk);
    @(negedge clk);
    chk("sb_drain", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
